// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART transmit controller.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Baud ticks per serial bit unless overridden at the top level
    localparam int OVERSAMPLE_DEF = 16;

    // Widest data word the parity helper accepts (DATA_BITS is at most 9)
    localparam int PARITY_MAX_W = 16;

    // Parity bit for a data word: even parity makes the total count of ones
    // even, odd parity inverts that. Zero-extension does not alter the XOR.
    function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data,
                                         input logic                    odd);
        return (^data) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_div.sv
`default_nettype none
// ============================================================================
// Module      : uart_tick_div
// Description : Baud tick divider. Counts 0..div_i and pulses tick_o on the
//               final count while enabled; held at zero when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tick_div #(
    parameter int DIV_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    // The count never exceeds div_i, so an all-ones divider cannot overflow
    assign tick_o = en_i && (cnt_q == div_i);

    // Next count: clear/disable force zero, tick wraps, otherwise increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_controller
// Description : UART transmit frame sequencer. Accepts a byte on a
//               valid/ready handshake and sends start, data (LSB first),
//               optional parity and one or two stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 10,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    input  logic                 cfg_two_stop,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS);

    state_t                 state_q, state_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [SUB_W-1:0]       sub_q, sub_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic                   par_en_q, par_en_d;
    logic                   two_stop_q, two_stop_d;
    logic                   par_q, par_d;

    logic                   w_accept;
    logic                   w_tick;
    logic                   w_bit_end;

    assign w_accept  = tx_valid && (state_q == IDLE);
    assign w_bit_end = w_tick && (sub_q == SUB_LAST);

    assign tx_ready = (state_q == IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

    uart_tick_div #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .clr_i  (w_accept),
        .div_i  (div_q),
        .tick_o (w_tick)
    );

    // Next-state, line value and counter updates; every change in a frame
    // happens at a bit boundary except the sub-tick advance
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        sub_d      = sub_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        div_d      = div_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        par_d      = par_q;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d    = START;
                    tx_d       = 1'b0;
                    shift_d    = tx_data;
                    sub_d      = '0;
                    bit_d      = '0;
                    stop_d     = 1'b0;
                    div_d      = cfg_div;
                    par_en_d   = cfg_parity_en;
                    two_stop_d = cfg_two_stop;
                    par_d      = calc_parity(PARITY_MAX_W'(tx_data), cfg_parity_odd);
                end
            end
            default: begin
                if (w_tick) begin
                    sub_d = w_bit_end ? '0 : sub_q + SUB_W'(1);
                end
                if (w_bit_end) begin
                    case (state_q)
                        START: begin
                            state_d = DATA;
                            tx_d    = shift_q[0];
                            shift_d = shift_q >> 1;
                            bit_d   = BIT_W'(1);
                        end
                        DATA: begin
                            if (bit_q == BITS_LAST) begin
                                if (par_en_q) begin
                                    state_d = PARITY;
                                    tx_d    = par_q;
                                end else begin
                                    state_d = STOP;
                                    tx_d    = 1'b1;
                                    stop_d  = 1'b0;
                                end
                            end else begin
                                tx_d    = shift_q[0];
                                shift_d = shift_q >> 1;
                                bit_d   = bit_q + BIT_W'(1);
                            end
                        end
                        PARITY: begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                            stop_d  = 1'b0;
                        end
                        STOP: begin
                            if (two_stop_q && !stop_q) begin
                                stop_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                tx_d    = 1'b1;
                                done_d  = 1'b1;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    endcase
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '0;
            sub_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            par_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            sub_q      <= sub_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            par_q      <= par_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_controller
// Description : Self-checking bench for uart_tx_controller. Expected line
//               waveforms are built from the frame format as a list of bit
//               values, each held for OVERSAMPLE*(div+1) clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_controller;

    localparam int OS = 16;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] cfg_div;
    logic       cfg_parity_en;
    logic       cfg_parity_odd;
    logic       cfg_two_stop;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_controller #(
        .DIV_WIDTH  (10),
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_div        (cfg_div),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .tx             (tx),
        .busy           (busy),
        .tx_done        (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [9:0] div;
        logic       pe;
        logic       po;
        logic       ts;
        int         mode;
        int         exp_len;
        logic       exp_par;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic [9:0] div,
                           input logic pe, input logic po, input logic ts);
        tx_data        = d;
        cfg_div        = div;
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_two_stop   = ts;
        tx_valid       = 1'b1;
    endtask

    // Called at a negedge with the request already driven. mode 0: drop
    // tx_valid after accept; 1: randomise all inputs during the frame;
    // 2: keep tx_valid high. stop_after>0 returns early at that cycle.
    task automatic run_frame(input logic [7:0] d, input logic [9:0] div,
                             input logic pe, input logic po, input logic ts,
                             input int mode, input int stop_after,
                             output int len_meas, output logic par_seen);
        logic bits[$];
        int   p, nb, l, last, werr, berr, first_bad;
        logic exp_tx;
        p = OS * (int'(div) + 1);
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(logic'(($countones(d) % 2 == 1) ^ po));
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        nb = bits.size();
        l = nb * p;
        last = (stop_after > 0) ? stop_after : l + 1;
        werr = 0; berr = 0; first_bad = -1; len_meas = -1; par_seen = 1'bx;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (tx_done === 1'b1 && len_meas < 0) len_meas = c - 1;
            if (c <= l) begin
                exp_tx = bits[(c - 1) / p];
                if (tx !== exp_tx) begin
                    werr++;
                    if (first_bad < 0) first_bad = c;
                end
                if (busy !== 1'b1 || tx_ready !== 1'b0 || tx_done !== 1'b0) berr++;
                if (pe && c == (1 + DB) * p + p / 2) par_seen = tx;
                if (mode == 1) begin
                    tx_valid       = 1'($urandom);
                    tx_data        = 8'($urandom);
                    cfg_div        = 10'($urandom);
                    cfg_parity_en  = 1'($urandom);
                    cfg_parity_odd = 1'($urandom);
                    cfg_two_stop   = 1'($urandom);
                end else begin
                    tx_valid = (mode == 2);
                end
            end else begin
                chk("done_tx_high", {31'd0, tx}, 32'd1);
                chk("done_pulse", {31'd0, tx_done}, 32'd1);
                chk("done_ready", {31'd0, tx_ready}, 32'd1);
                chk("done_not_busy", {31'd0, busy}, 32'd0);
                tx_valid = (mode == 2);
            end
        end
        if (werr != 0) $display("FAIL wave: %0d bad tx cycles, first at cycle %0d (data %0h)", werr, first_bad, d);
        chk("wave_errors", werr, 0);
        chk("in_frame_status_errors", berr, 0);
        if (stop_after == 0) chk("frame_len_model", len_meas, l);
    endtask

    // Idle line: high, ready, not busy, no done pulse
    task automatic idle(input int n);
        int err = 0;
        tx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) err++;
        end
        chk("idle_errors", err, 0);
    endtask

    // Abort a frame with a one-edge reset and check the recovered state
    task automatic reset_pulse();
        tx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        idle(3);
    endtask

    initial begin
        int   len;
        logic par;
        logic [7:0] rd;
        logic [9:0] rdiv;
        logic rpe, rpo, rts;
        int   rmode;

        vt[0] = '{d: 8'hA5, div: 10'd0, pe: 1'b0, po: 1'b0, ts: 1'b0, mode: 0, exp_len: 160, exp_par: 1'b0};
        vt[1] = '{d: 8'h07, div: 10'd3, pe: 1'b1, po: 1'b0, ts: 1'b0, mode: 1, exp_len: 704, exp_par: 1'b1};
        vt[2] = '{d: 8'h00, div: 10'd0, pe: 1'b1, po: 1'b1, ts: 1'b1, mode: 1, exp_len: 192, exp_par: 1'b1};
        vt[3] = '{d: 8'hFF, div: 10'd1, pe: 1'b1, po: 1'b1, ts: 1'b0, mode: 0, exp_len: 352, exp_par: 1'b1};
        vt[4] = '{d: 8'h03, div: 10'd2, pe: 1'b1, po: 1'b0, ts: 1'b1, mode: 0, exp_len: 576, exp_par: 1'b0};

        rst_n = 1'b0;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        cfg_div = 10'd0;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, tx_ready}, 32'd1);
        chk("reset_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Directed frames with hand-computed length and parity bit
        for (int i = 0; i < 5; i++) begin
            set_cfg(vt[i].d, vt[i].div, vt[i].pe, vt[i].po, vt[i].ts);
            run_frame(vt[i].d, vt[i].div, vt[i].pe, vt[i].po, vt[i].ts, vt[i].mode, 0, len, par);
            chk("table_len", len, vt[i].exp_len);
            if (vt[i].pe) chk("table_parity", {31'd0, par}, {31'd0, vt[i].exp_par});
            idle(2);
        end

        // tx_valid held high across two frames: accept in the done cycle
        set_cfg(8'h55, 10'd0, 1'b0, 1'b0, 1'b0);
        run_frame(8'h55, 10'd0, 1'b0, 1'b0, 1'b0, 2, 0, len, par);
        tx_data = 8'hAA;
        run_frame(8'hAA, 10'd0, 1'b0, 1'b0, 1'b0, 0, 0, len, par);
        idle(2);

        // Reset mid-DATA, then a clean frame
        set_cfg(8'hC3, 10'd0, 1'b0, 1'b0, 1'b0);
        run_frame(8'hC3, 10'd0, 1'b0, 1'b0, 1'b0, 0, 53, len, par);
        chk("no_done_before_reset", len, 32'hFFFF_FFFF);
        reset_pulse();
        set_cfg(8'h3C, 10'd0, 1'b0, 1'b0, 1'b0);
        run_frame(8'h3C, 10'd0, 1'b0, 1'b0, 1'b0, 0, 0, len, par);
        idle(2);

        // All-ones divider: start bit stays low, then abort
        set_cfg(8'h81, 10'h3FF, 1'b1, 1'b0, 1'b1);
        run_frame(8'h81, 10'h3FF, 1'b1, 1'b0, 1'b1, 0, 400, len, par);
        reset_pulse();

        // Randomised frames, sometimes chained, sometimes with noise inputs
        for (int k = 0; k < 12; k++) begin
            rd    = 8'($urandom);
            rdiv  = 10'($urandom_range(0, 3));
            rpe   = 1'($urandom);
            rpo   = 1'($urandom);
            rts   = 1'($urandom);
            rmode = int'($urandom_range(0, 1));
            set_cfg(rd, rdiv, rpe, rpo, rts);
            run_frame(rd, rdiv, rpe, rpo, rts, rmode, 0, len, par);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
